pixel_stream_tracker: RTL and testbench

- Upstream front end of the laser-detection path.
- Accepts an AXI4-Stream video feed (tuser = start of frame, tlast = end of line) and emits one pixel per accepted beat with its column and row. It also produces the per-frame clear pulse that re-arms the laser detector.
- Checks frame geometry against fixed dimensions and flags malformed lines and frames.

---
 rtl/pixel_stream_tracker_if.sv | 29 ++
 rtl/pixel_stream_tracker.sv | 152 +++++++++++++++
 tb/tb_pixel_stream_tracker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tracker_if.sv
// rtl/pixel_stream_tracker_if.sv - video stream bundle (tdata/tvalid/tready/tuser/tlast)
// Ports (as modports):
//   master : drives tdata, tvalid, tuser (start of frame), tlast (end of line); samples tready
//   slave  : samples tdata, tvalid, tuser, tlast; drives tready
interface pixel_stream_tracker_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pixel_stream_tracker.sv
// rtl/pixel_stream_tracker.sv - video front end: pixel coordinates, detector clear, geometry checks
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   s_axis (slave)       : input video beats; tuser = start of frame, tlast = end of line
//   err_clear            : clears err_eol / err_sof (a same-cycle set wins)
//   pixel_data/col/row   : pixel and its coordinates, qualified by pixel_en
//   det_clear            : one-cycle pulse one cycle ahead of pixel (0,0)
//   frame_start/done     : pulses aligned with the first / last pixel of a frame
//   frame_count          : completed frames, wraps
//   err_eol, err_sof     : sticky line-length and mid-frame-SOF flags
module pixel_stream_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIXEL_SIZE = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_stream_tracker_if.slave s_axis,
    input  logic                  err_clear,
    output logic [PIXEL_SIZE-1:0] pixel_data,
    output logic [15:0]           pixel_col,
    output logic [15:0]           pixel_row,
    output logic                  pixel_en,
    output logic                  det_clear,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  err_eol,
    output logic                  err_sof
);
    localparam logic [0:0]  WAIT_SOF = 1'b0;
    localparam logic [0:0]  ACTIVE   = 1'b1;
    localparam logic [15:0] COL_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] ROW_LAST = 16'(V_ACTIVE - 1);

    logic [0:0]  state;
    logic [15:0] col;
    logic [15:0] row;
    logic        tready_q;

    // Beat classification for the current cycle.
    logic        beat;
    logic        take;
    logic        is_sof;
    logic [15:0] eff_col;
    logic [15:0] eff_row;
    logic        at_col_last;
    logic        line_end;
    logic        frame_end;

    // Stage 1: coordinates resolved, det_clear issued one cycle ahead of the pixel.
    logic                  s1_valid;
    logic [PIXEL_SIZE-1:0] s1_data;
    logic [15:0]           s1_col;
    logic [15:0]           s1_row;
    logic                  s1_sof;
    logic                  s1_done;
    logic                  s1_eol_err;
    logic                  s1_sof_err;

    assign s_axis.tready = tready_q;

    always_comb begin
        beat        = s_axis.tvalid & tready_q;
        is_sof      = s_axis.tuser;
        // Beats before the first SOF carry no position and are dropped.
        take        = beat & ((state == ACTIVE) | is_sof);
        // An SOF always restarts at (0,0), even mid-frame.
        eff_col     = is_sof ? 16'd0 : col;
        eff_row     = is_sof ? 16'd0 : row;
        at_col_last = (eff_col == COL_LAST);
        line_end    = s_axis.tlast | at_col_last;
        frame_end   = line_end & (eff_row == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tready_q <= 1'b0;
            state    <= WAIT_SOF;
            col      <= 16'd0;
            row      <= 16'd0;
        end else begin
            tready_q <= 1'b1;
            if (take) begin
                if (frame_end) begin
                    state <= WAIT_SOF;
                    col   <= 16'd0;
                    row   <= 16'd0;
                end else if (line_end) begin
                    state <= ACTIVE;
                    col   <= 16'd0;
                    row   <= eff_row + 16'd1;
                end else begin
                    state <= ACTIVE;
                    col   <= eff_col + 16'd1;
                    row   <= eff_row;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_col     <= 16'd0;
            s1_row     <= 16'd0;
            s1_sof     <= 1'b0;
            s1_done    <= 1'b0;
            s1_eol_err <= 1'b0;
            s1_sof_err <= 1'b0;
            det_clear  <= 1'b0;
        end else begin
            s1_valid   <= take;
            s1_data    <= s_axis.tdata;
            s1_col     <= eff_col;
            s1_row     <= eff_row;
            s1_sof     <= take & is_sof;
            s1_done    <= take & frame_end;
            // Length mismatch in either direction: early tlast or missing tlast.
            s1_eol_err <= take & (s_axis.tlast ^ at_col_last);
            s1_sof_err <= take & is_sof & (state == ACTIVE);
            det_clear  <= take & is_sof;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_en    <= 1'b0;
            pixel_data  <= '0;
            pixel_col   <= 16'd0;
            pixel_row   <= 16'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
            err_eol     <= 1'b0;
            err_sof     <= 1'b0;
        end else begin
            pixel_en    <= s1_valid;
            pixel_data  <= s1_data;
            pixel_col   <= s1_col;
            pixel_row   <= s1_row;
            frame_start <= s1_sof;
            frame_done  <= s1_done;
            if (s1_done) begin
                frame_count <= frame_count + 16'd1;
            end
            err_eol <= s1_eol_err | (err_eol & ~err_clear);
            err_sof <= s1_sof_err | (err_sof & ~err_clear);
        end
    end
endmodule

// File: tb/tb_pixel_stream_tracker.sv
// tb/tb_pixel_stream_tracker.sv - scoreboard bench for pixel_stream_tracker
module tb_pixel_stream_tracker;
    localparam int H = 4;
    localparam int V = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clear = 1'b0;
    logic [23:0] pixel_data;
    logic [15:0] pixel_col;
    logic [15:0] pixel_row;
    logic        pixel_en;
    logic        det_clear;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_eol;
    logic        err_sof;

    pixel_stream_tracker_if #(.DATA_W(24)) s_axis ();

    pixel_stream_tracker #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .PIXEL_SIZE(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axis(s_axis),
        .err_clear(err_clear),
        .pixel_data(pixel_data),
        .pixel_col(pixel_col),
        .pixel_row(pixel_row),
        .pixel_en(pixel_en),
        .det_clear(det_clear),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .err_eol(err_eol),
        .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic [15:0] c;
        logic [15:0] r;
        logic        s;
        logic        f;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        m_active = 1'b0;
    logic [15:0] m_col = 16'd0;
    logic [15:0] m_row = 16'd0;
    logic [23:0] next_data = 24'h100;
    logic        prev_dc = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (pixel_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_pixel", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("px_data", {8'd0, pixel_data}, {8'd0, e.d});
                check_val("px_col", {16'd0, pixel_col}, {16'd0, e.c});
                check_val("px_row", {16'd0, pixel_row}, {16'd0, e.r});
                check_val("px_start", {31'd0, frame_start}, {31'd0, e.s});
                check_val("px_done", {31'd0, frame_done}, {31'd0, e.f});
                check_val("px_latency", cyc, e.cyc);
            end
            if (frame_start === 1'b1) check_val("dc_lead", {31'd0, prev_dc}, 32'd1);
        end
        if (prev_dc) check_val("dc_follow", {31'd0, pixel_en & frame_start}, 32'd1);
        prev_dc = det_clear;
    end

    // Spec model: drop pre-SOF beats, SOF restarts at (0,0), wrap on tlast or last column.
    task automatic send(input logic user, input logic last);
        exp_t        e;
        logic [15:0] ec;
        logic [15:0] er;
        logic        le;
        s_axis.tdata  = next_data;
        s_axis.tuser  = user;
        s_axis.tlast  = last;
        s_axis.tvalid = 1'b1;
        if (s_axis.tready === 1'b1 && (m_active || user)) begin
            ec = user ? 16'd0 : m_col;
            er = user ? 16'd0 : m_row;
            le = last || (ec == 16'(H - 1));
            e.d = next_data;
            e.c = ec;
            e.r = er;
            e.s = user;
            e.f = le && (er == 16'(V - 1));
            e.cyc = cyc + 2;
            sb_q.push_back(e);
            if (e.f) begin
                m_active = 1'b0; m_col = 0; m_row = 0;
            end else if (le) begin
                m_active = 1'b1; m_col = 0; m_row = er + 1;
            end else begin
                m_active = 1'b1; m_col = ec + 1; m_row = er;
            end
        end
        next_data = next_data + 24'h1;
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tuser  = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int r0, input logic bubble);
        for (int r = r0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                send(r == 0 && c == 0, c == H - 1);
                if (bubble) idle(1);
            end
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tuser  = 1'b0;
        s_axis.tlast  = 1'b0;
        idle(3);
        check_val("rst_tready", {31'd0, s_axis.tready}, 32'd0);
        check_val("rst_pixel_en", {31'd0, pixel_en}, 32'd0);
        check_val("rst_det_clear", {31'd0, det_clear}, 32'd0);
        check_val("rst_count", {16'd0, frame_count}, 32'd0);
        check_val("rst_errs", {30'd0, err_eol, err_sof}, 32'd0);
        reset = 1'b0;
        idle(2);
        check_val("tready_up", {31'd0, s_axis.tready}, 32'd1);

        // Clean frame
        send_rows(0, 1'b0);
        idle(3);
        check_val("clean_count", {16'd0, frame_count}, 32'd1);
        check_val("clean_errs", {30'd0, err_eol, err_sof}, 32'd0);

        // Pre-SOF garbage then a clean frame
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send_rows(0, 1'b0);
        idle(3);
        check_val("garbage_count", {16'd0, frame_count}, 32'd2);
        check_val("garbage_errs", {30'd0, err_eol, err_sof}, 32'd0);

        // Early EOL at col 2 of row 0
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send_rows(1, 1'b0);
        idle(3);
        check_val("early_eol", {31'd0, err_eol}, 32'd1);
        check_val("early_count", {16'd0, frame_count}, 32'd3);
        pulse_clear();
        check_val("eol_cleared", {31'd0, err_eol}, 32'd0);

        // Missing EOL on row 0
        for (int c = 0; c < H; c++) send(c == 0, 1'b0);
        send_rows(1, 1'b0);
        idle(3);
        check_val("missing_eol", {31'd0, err_eol}, 32'd1);
        check_val("missing_sof_err", {31'd0, err_sof}, 32'd0);
        check_val("missing_count", {16'd0, frame_count}, 32'd4);
        pulse_clear();

        // Mid-frame SOF at beat 6
        for (int i = 0; i < 6; i++) send(i == 0, i == H - 1);
        send(1'b1, 1'b0);
        idle(3);
        check_val("midsof_err", {31'd0, err_sof}, 32'd1);
        check_val("midsof_eol", {31'd0, err_eol}, 32'd0);
        check_val("midsof_count", {16'd0, frame_count}, 32'd4);
        for (int c = 1; c < H; c++) send(1'b0, c == H - 1);
        send_rows(1, 1'b0);
        idle(3);
        check_val("midsof_done_count", {16'd0, frame_count}, 32'd5);
        pulse_clear();
        check_val("sof_cleared", {31'd0, err_sof}, 32'd0);

        // Bubbles every other cycle
        send_rows(0, 1'b1);
        idle(3);
        check_val("bubble_count", {16'd0, frame_count}, 32'd6);

        // Reset while pixel (2,1) is on the output
        for (int i = 0; i < 2 * H; i++) send(i == 0, (i % H) == H - 1);
        reset = 1'b1;
        idle(1);
        check_val("midrst_inflight", sb_q.size(), 32'd1);
        sb_q.delete();
        m_active = 1'b0; m_col = 0; m_row = 0;
        check_val("midrst_pixel_en", {31'd0, pixel_en}, 32'd0);
        check_val("midrst_outs", {pixel_col, pixel_row}, 32'd0);
        check_val("midrst_data", {8'd0, pixel_data}, 32'd0);
        check_val("midrst_count", {16'd0, frame_count}, 32'd0);
        check_val("midrst_flags", {27'd0, det_clear, frame_start, frame_done, err_eol, err_sof}, 32'd0);
        check_val("midrst_tready", {31'd0, s_axis.tready}, 32'd0);
        idle(1);
        reset = 1'b0;
        idle(4);
        send_rows(0, 1'b0);
        idle(4);
        check_val("postrst_count", {16'd0, frame_count}, 32'd1);
        check_val("sb_drain", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
